// File: rtl/i2c_target_regfile.sv
`timescale 1ns/1ps
// i2c_target_regfile
// I2C target with a small byte-addressable register file. SCL and SDA are
// oversampled on clk_i. The target detects START and STOP, matches a 7-bit
// address and ACKs it. A write transfer sends the register pointer first and
// then data bytes. A read transfer returns data starting at the pointer. The
// pointer auto-increments after each byte and wraps at MEM_DEPTH.
//
// Ports
//   clk_i      system clock, at least 8x the SCL frequency
//   rst_ni     asynchronous active-low reset
//   scl_i      bus SCL
//   sda_i      bus SDA
//   sda_o      open-drain SDA drive (0 pulls low, 1 releases)
//   busy_o     high from an address match until STOP or repeated START
//   wr_strb_o  one-cycle pulse per data byte stored
//   wr_idx_o   register index of the stored byte
//   wr_data_o  stored byte
module i2c_target_regfile #(
  parameter logic [6:0] SLAVE_ADDR = 7'h22,
  parameter int         MEM_DEPTH  = 16,
  parameter int         PTR_WIDTH  = $clog2(MEM_DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 scl_i,
  input  logic                 sda_i,
  output logic                 sda_o,
  output logic                 busy_o,
  output logic                 wr_strb_o,
  output logic [PTR_WIDTH-1:0] wr_idx_o,
  output logic [7:0]           wr_data_o
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, WR_PTR, WR_ACK, WR_DATA, RD_BYTE, RD_ACK, IGNORE
  } state_t;

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [7:0]           shreg_q, shreg_d;
  logic [PTR_WIDTH-1:0] ptr_q, ptr_d;
  logic                 sda_out_q, sda_d;
  logic                 busy_q, busy_d;
  logic                 rw_q, rw_d;
  logic                 strb_q, strb_d;
  logic [PTR_WIDTH-1:0] idx_q, idx_d;
  logic [7:0]           wdata_q, wdata_d;
  logic                 mem_we;
  logic [7:0]           mem_q [MEM_DEPTH];

  // Two synchronizer flops plus one history flop per bus line. They reset
  // high, which matches an idle bus and avoids false events.
  logic scl_meta_q, scl_q, scl_hist_q;
  logic sda_meta_q, sda_q, sda_hist_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      {scl_hist_q, scl_q, scl_meta_q} <= 3'b111;
      {sda_hist_q, sda_q, sda_meta_q} <= 3'b111;
    end else begin
      {scl_hist_q, scl_q, scl_meta_q} <= {scl_q, scl_meta_q, scl_i};
      {sda_hist_q, sda_q, sda_meta_q} <= {sda_q, sda_meta_q, sda_i};
    end
  end

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] byte_in, rd_byte;

  assign scl_rise  = scl_q & ~scl_hist_q;
  assign scl_fall  = ~scl_q & scl_hist_q;
  assign start_det = scl_q & sda_hist_q & ~sda_q;
  assign stop_det  = scl_q & ~sda_hist_q & sda_q;
  // The complete byte is formed on the 8th rise with the bit being sampled.
  assign byte_in   = {shreg_q[6:0], sda_q};
  assign rd_byte   = mem_q[ptr_q];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    ptr_d   = ptr_q;
    sda_d   = sda_out_q;
    busy_d  = busy_q;
    rw_d    = rw_q;
    strb_d  = 1'b0;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    mem_we  = 1'b0;

    if (start_det) begin
      state_d = ADDR;
      cnt_d   = 4'd0;
      sda_d   = 1'b1;
      busy_d  = 1'b0;
    end else if (stop_det) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
      sda_d   = 1'b1;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ADDR, WR_PTR, WR_DATA: begin
          if (scl_rise) begin
            shreg_d = byte_in;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d = 4'd0;
              if (state_q == ADDR) begin
                if (byte_in[7:1] == SLAVE_ADDR) begin
                  busy_d  = 1'b1;
                  rw_d    = byte_in[0];
                  state_d = ADDR_ACK;
                end else begin
                  state_d = IGNORE;
                end
              end else if (state_q == WR_PTR) begin
                ptr_d   = byte_in[PTR_WIDTH-1:0];
                state_d = WR_ACK;
              end else begin
                mem_we  = 1'b1;
                strb_d  = 1'b1;
                idx_d   = ptr_q;
                wdata_d = byte_in;
                ptr_d   = ptr_q + PTR_WIDTH'(1);
                state_d = WR_ACK;
              end
            end
          end
        end

        // The released SDA tells the two ACK phases apart. The first SCL fall
        // pulls SDA low. The next fall releases it and leaves the ACK state.
        ADDR_ACK, WR_ACK: begin
          if (scl_fall) begin
            if (sda_out_q) begin
              sda_d = 1'b0;
            end else begin
              sda_d = 1'b1;
              cnt_d = 4'd0;
              if (state_q == WR_ACK) begin
                state_d = WR_DATA;
              end else if (rw_q) begin
                state_d = RD_BYTE;
                sda_d   = rd_byte[7];
                shreg_d = {rd_byte[6:0], 1'b0};
              end else begin
                state_d = WR_PTR;
              end
            end
          end
        end

        // shreg_q holds the bits still to send, MSB first.
        RD_BYTE: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              sda_d   = 1'b1;
              state_d = RD_ACK;
            end else begin
              sda_d   = shreg_q[7];
              shreg_d = {shreg_q[6:0], 1'b0};
            end
          end
        end

        // A count of 9 marks that the master ACKed. On the following fall the
        // next byte is loaded from the already-advanced pointer.
        RD_ACK: begin
          if (scl_rise) begin
            ptr_d = ptr_q + PTR_WIDTH'(1);
            if (sda_q) state_d = IGNORE;
            else       cnt_d   = 4'd9;
          end else if (scl_fall && cnt_q == 4'd9) begin
            state_d = RD_BYTE;
            cnt_d   = 4'd0;
            sda_d   = rd_byte[7];
            shreg_d = {rd_byte[6:0], 1'b0};
          end
        end

        IDLE, IGNORE: begin
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      shreg_q   <= 8'h00;
      ptr_q     <= '0;
      sda_out_q <= 1'b1;
      busy_q    <= 1'b0;
      rw_q      <= 1'b0;
      strb_q    <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= 8'h00;
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      ptr_q     <= ptr_d;
      sda_out_q <= sda_d;
      busy_q    <= busy_d;
      rw_q      <= rw_d;
      strb_q    <= strb_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      if (mem_we) mem_q[ptr_q] <= byte_in;
    end
  end

  assign sda_o     = sda_out_q;
  assign busy_o    = busy_q;
  assign wr_strb_o = strb_q;
  assign wr_idx_o  = idx_q;
  assign wr_data_o = wdata_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
`timescale 1ns/1ps
module tb_i2c_target_regfile;
  localparam int Q = 8;  // clk cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  wire        sda_line;
  logic       sda_o, busy_o, wr_strb_o;
  logic [3:0] wr_idx_o;
  logic [7:0] wr_data_o;

  assign sda_line = m_sda & sda_o;
  always #5 clk = ~clk;

  i2c_target_regfile #(.SLAVE_ADDR(7'h22), .MEM_DEPTH(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .scl_i(scl), .sda_i(sda_line),
    .sda_o(sda_o), .busy_o(busy_o), .wr_strb_o(wr_strb_o),
    .wr_idx_o(wr_idx_o), .wr_data_o(wr_data_o)
  );

  int total = 0;
  int bad = 0;

  // Bus monitor: logs write strobes and counts SDA pulls, busy cycles and
  // SDA changes while SCL is high.
  logic [3:0] strb_idx [64];
  logic [7:0] strb_dat [64];
  int strb_n = 0;
  int sda_low_cnt = 0;
  int busy_hi_cnt = 0;
  int hi_chg = 0;
  logic sda_prev = 1'b1;

  always @(negedge clk) begin
    if (wr_strb_o === 1'b1 && strb_n < 64) begin
      strb_idx[strb_n] = wr_idx_o;
      strb_dat[strb_n] = wr_data_o;
      strb_n++;
    end
    if (sda_o === 1'b0) sda_low_cnt++;
    if (busy_o === 1'b1) busy_hi_cnt++;
    if (rst_n && scl && sda_o !== sda_prev) hi_chg++;
    sda_prev = sda_o;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_q(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clk_bit(input logic b, output logic s);
    wait_q(Q); m_sda = b;
    wait_q(Q); scl = 1'b1;
    wait_q(Q); s = sda_line;
    wait_q(Q); scl = 1'b0;
  endtask

  task automatic i2c_start();
    if (!scl) begin
      wait_q(Q); m_sda = 1'b1;
      wait_q(Q); scl = 1'b1;
    end else begin
      m_sda = 1'b1;
    end
    wait_q(Q); m_sda = 1'b0;
    wait_q(Q); scl = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_q(Q); m_sda = 1'b0;
    wait_q(Q); scl = 1'b1;
    wait_q(Q); m_sda = 1'b1;
    wait_q(2*Q);
  endtask

  // ack_bit is the sampled 9th bit: 0 means the target ACKed.
  task automatic write_byte(input logic [7:0] b, output logic ack_bit);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, ack_bit);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic s;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      clk_bit(1'b1, s);
      d = {d[6:0], s};
    end
    clk_bit(nack, s);
  endtask

  task automatic test_reset();
    logic a;
    logic [7:0] d;
    rst_n = 1'b0;
    wait_q(5);
    total++; if (sda_o !== 1'b1) begin bad++; $display("FAIL rst_sda got %b want 1", sda_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rst_busy got %b want 0", busy_o); end
    total++; if (wr_strb_o !== 1'b0) begin bad++; $display("FAIL rst_strb got %b want 0", wr_strb_o); end
    total++; if (wr_idx_o !== 4'h0 || wr_data_o !== 8'h00) begin
      bad++; $display("FAIL rst_wr got %h/%h want 0/00", wr_idx_o, wr_data_o); end
    rst_n = 1'b1;
    wait_q(4);
    i2c_start();
    write_byte(8'h44, a);
    total++; if (a !== 1'b0) begin bad++; $display("FAIL rst_addr_ack got %b want 0", a); end
    write_byte(8'h00, a);
    i2c_start();
    write_byte(8'h45, a);
    for (int i = 0; i < 16; i++) begin
      read_byte(i == 15, d);
      total++; if (d !== 8'h00) begin bad++; $display("FAIL rst_mem%0d got %h want 00", i, d); end
    end
    i2c_stop();
  endtask

  task automatic test_write_burst();
    logic a;
    int n0 = strb_n;
    logic [7:0] bytes [4];
    bytes = '{8'h44, 8'h03, 8'hA5, 8'h5A};
    i2c_start();
    for (int i = 0; i < 4; i++) begin
      write_byte(bytes[i], a);
      total++; if (a !== 1'b0) begin bad++; $display("FAIL wb_ack%0d got %b want 0", i, a); end
    end
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL wb_busy got %b want 1", busy_o); end
    i2c_stop();
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL wb_busy_stop got %b want 0", busy_o); end
    total++; if (strb_n - n0 !== 2) begin bad++; $display("FAIL wb_strb_cnt got %0d want 2", strb_n - n0); end
    total++; if (strb_idx[n0] !== 4'h3 || strb_dat[n0] !== 8'hA5) begin
      bad++; $display("FAIL wb_strb0 got %h/%h want 3/a5", strb_idx[n0], strb_dat[n0]); end
    total++; if (strb_idx[n0+1] !== 4'h4 || strb_dat[n0+1] !== 8'h5A) begin
      bad++; $display("FAIL wb_strb1 got %h/%h want 4/5a", strb_idx[n0+1], strb_dat[n0+1]); end
  endtask

  task automatic test_combined_read();
    logic a;
    logic [7:0] d;
    i2c_start(); write_byte(8'h44, a); write_byte(8'h05, a); write_byte(8'hC3, a); i2c_stop();
    i2c_start(); write_byte(8'h44, a); write_byte(8'h03, a);
    i2c_start(); write_byte(8'h45, a);
    total++; if (a !== 1'b0) begin bad++; $display("FAIL cr_addr_ack got %b want 0", a); end
    read_byte(1'b0, d);
    total++; if (d !== 8'hA5) begin bad++; $display("FAIL cr_byte0 got %h want a5", d); end
    read_byte(1'b1, d);
    total++; if (d !== 8'h5A) begin bad++; $display("FAIL cr_byte1 got %h want 5a", d); end
    i2c_stop();
    // A current-address read shows where the pointer ended.
    i2c_start(); write_byte(8'h45, a); read_byte(1'b1, d); i2c_stop();
    total++; if (d !== 8'hC3) begin bad++; $display("FAIL cr_ptr5 got %h want c3", d); end
  endtask

  task automatic test_addr_mismatch();
    logic a0, a1;
    int low0 = sda_low_cnt;
    int busy0 = busy_hi_cnt;
    int n0 = strb_n;
    i2c_start(); write_byte(8'h46, a0); write_byte(8'h11, a1); i2c_stop();
    total++; if (a0 !== 1'b1 || a1 !== 1'b1) begin bad++; $display("FAIL mm_ack got %b%b want 11", a0, a1); end
    total++; if (sda_low_cnt != low0) begin bad++; $display("FAIL mm_sda_low got %0d want 0", sda_low_cnt - low0); end
    total++; if (busy_hi_cnt != busy0) begin bad++; $display("FAIL mm_busy got %0d want 0", busy_hi_cnt - busy0); end
    total++; if (strb_n != n0) begin bad++; $display("FAIL mm_strb got %0d want 0", strb_n - n0); end
  endtask

  task automatic test_wrap();
    logic a;
    logic [7:0] d;
    int n0 = strb_n;
    i2c_start(); write_byte(8'h44, a); write_byte(8'h0F, a);
    write_byte(8'h11, a); write_byte(8'h22, a); i2c_stop();
    total++; if (strb_n - n0 !== 2) begin bad++; $display("FAIL wr_strb_cnt got %0d want 2", strb_n - n0); end
    total++; if (strb_idx[n0] !== 4'hF || strb_dat[n0] !== 8'h11) begin
      bad++; $display("FAIL wr_strb0 got %h/%h want f/11", strb_idx[n0], strb_dat[n0]); end
    total++; if (strb_idx[n0+1] !== 4'h0 || strb_dat[n0+1] !== 8'h22) begin
      bad++; $display("FAIL wr_strb1 got %h/%h want 0/22", strb_idx[n0+1], strb_dat[n0+1]); end
    i2c_start(); write_byte(8'h44, a); write_byte(8'h0F, a);
    i2c_start(); write_byte(8'h45, a);
    read_byte(1'b0, d);
    total++; if (d !== 8'h11) begin bad++; $display("FAIL wr_rd15 got %h want 11", d); end
    read_byte(1'b1, d);
    total++; if (d !== 8'h22) begin bad++; $display("FAIL wr_rd0 got %h want 22", d); end
    i2c_stop();
  endtask

  task automatic test_abort();
    logic a, s;
    logic [7:0] d;
    int n0;
    i2c_start(); write_byte(8'h44, a); write_byte(8'h07, a); write_byte(8'h3C, a); i2c_stop();
    n0 = strb_n;
    i2c_start(); write_byte(8'h44, a); write_byte(8'h07, a);
    clk_bit(1'b1, s); clk_bit(1'b0, s); clk_bit(1'b1, s); clk_bit(1'b0, s);
    i2c_stop();
    total++; if (strb_n != n0) begin bad++; $display("FAIL ab_strb got %0d want 0", strb_n - n0); end
    i2c_start(); write_byte(8'h45, a);
    read_byte(1'b0, d);
    total++; if (d !== 8'h3C) begin bad++; $display("FAIL ab_ptr_mem got %h want 3c", d); end
    // mem[8] is zero, so the target is pulling SDA low for each bit now.
    clk_bit(1'b1, s); clk_bit(1'b1, s);
    wait_q(Q);
    total++; if (sda_o !== 1'b0) begin bad++; $display("FAIL ab_pre_rst got %b want 0", sda_o); end
    rst_n = 1'b0;
    #1;
    total++; if (sda_o !== 1'b1) begin bad++; $display("FAIL ab_rst_sda got %b want 1", sda_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL ab_rst_busy got %b want 0", busy_o); end
    wait_q(Q); scl = 1'b1;
    wait_q(Q); m_sda = 1'b1;
    wait_q(Q); rst_n = 1'b1;
    wait_q(Q);
    i2c_start(); write_byte(8'h44, a); write_byte(8'h07, a);
    i2c_start(); write_byte(8'h45, a); read_byte(1'b1, d); i2c_stop();
    total++; if (d !== 8'h00) begin bad++; $display("FAIL ab_mem_cleared got %h want 00", d); end
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_combined_read();
    test_addr_mismatch();
    test_wrap();
    test_abort();
    total++; if (hi_chg != 0) begin bad++; $display("FAIL sda_chg_scl_high got %0d want 0", hi_chg); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
